// File: rtl/obi_stream_writer_if.sv
// OBI manager bus bundle for the stream-to-memory writer.
// The manager drives the request channel (req plus the a.* fields); the
// memory side answers with gnt and the response channel (rvalid, r.err).
interface obi_stream_writer_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  aid;
  logic        gnt;
  logic        rvalid;
  logic        err;

  modport master (
    output req, addr, we, be, wdata, aid,
    input  gnt, rvalid, err
  );

  modport slave (
    input  req, addr, we, be, wdata, aid,
    output gnt, rvalid, err
  );
endinterface

// File: rtl/obi_stream_writer.sv
// OBI manager write-DMA: drains a 32-bit valid/ready word stream into a
// byte address range in memory. One command at a time, at most one
// outstanding OBI transaction. The final word of a command carries byte
// enables trimmed to the remaining byte count.
module obi_stream_writer #(
  parameter logic [3:0]  AID      = 4'd0,
  parameter int unsigned LenWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                testmode_i,
  obi_stream_writer_if.master mgr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         awaddr,
  input  logic [LenWidth-1:0] awlen,
  input  logic                rvalid,
  output logic                rready,
  input  logic [31:0]         rdata,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    DATA = 3'd1,
    REQ  = 3'd2,
    RESP = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e              state_q;
  logic [31:0]         addr_q;
  logic [LenWidth-1:0] rem_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [3:0]          aid_q;
  logic                req_q;
  logic                we_q;
  logic                rready_q;
  logic                err_q;

  // Test mode has no functional effect; the low address bits are dropped.
  logic unused_inputs;
  assign unused_inputs = ^{testmode_i, awaddr[1:0]};

  // Byte enables for the word about to be written: full word unless fewer
  // than four bytes remain, in which case only the low rem bytes are enabled.
  function automatic logic [3:0] be_for(input logic [LenWidth-1:0] rem);
    logic [3:0] be;
    if (rem >= LenWidth'(4)) begin
      be = 4'b1111;
    end else begin
      case (rem[1:0])
        2'd1:    be = 4'b0001;
        2'd2:    be = 4'b0011;
        2'd3:    be = 4'b0111;
        default: be = 4'b0000;
      endcase
    end
    return be;
  endfunction

  // Remaining byte count after one word has been granted, floored at zero.
  function automatic logic [LenWidth-1:0] rem_after(input logic [LenWidth-1:0] rem);
    return (rem >= LenWidth'(4)) ? (rem - LenWidth'(4)) : '0;
  endfunction

  assign mgr.req   = req_q;
  assign mgr.addr  = addr_q;
  assign mgr.we    = we_q;
  assign mgr.be    = be_q;
  assign mgr.wdata = wdata_q;
  assign mgr.aid   = aid_q;

  assign awready = (state_q == IDLE);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = (state_q == DONE);
  assign rready  = rready_q;
  assign err_o   = err_q;

  // Command FSM: accept, pull one stream word, issue it on OBI, wait for the
  // response, repeat until the byte count is exhausted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      aid_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      rready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (awvalid) begin
            addr_q <= {awaddr[31:2], 2'b00};
            rem_q  <= awlen;
            err_q  <= 1'b0;
            if (awlen == '0) begin
              state_q <= DONE;
            end else begin
              state_q  <= DATA;
              rready_q <= 1'b1;
            end
          end
        end
        DATA: begin
          if (rvalid && rready_q) begin
            wdata_q  <= rdata;
            rready_q <= 1'b0;
            req_q    <= 1'b1;
            we_q     <= 1'b1;
            be_q     <= be_for(rem_q);
            aid_q    <= AID;
            state_q  <= REQ;
          end
        end
        REQ: begin
          // Request fields stay frozen until the grant; no retraction.
          if (mgr.gnt) begin
            req_q   <= 1'b0;
            addr_q  <= addr_q + 32'd4;
            rem_q   <= rem_after(rem_q);
            state_q <= RESP;
          end
        end
        RESP: begin
          // An error response is recorded but the transfer carries on.
          if (mgr.rvalid) begin
            if (mgr.err) begin
              err_q <= 1'b1;
            end
            if (rem_q == '0) begin
              state_q <= DONE;
            end else begin
              state_q  <= DATA;
              rready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_stream_writer.sv
// Bench for obi_stream_writer: directed commands with hand-computed
// expected writes queued in a scoreboard, a memory responder with
// configurable grant/response delays and a stream source with gaps.
module tb_obi_stream_writer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        testmode_i;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [31:0] awlen;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  obi_stream_writer_if mgr();

  obi_stream_writer #(.AID(4'd0), .LenWidth(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .testmode_i (testmode_i),
    .mgr        (mgr),
    .awvalid    (awvalid),
    .awready    (awready),
    .awaddr     (awaddr),
    .awlen      (awlen),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  int gnt_dly = 0;
  int rsp_dly = 0;
  int gap     = 0;

  // {addr, be, wdata, we, aid}
  logic [72:0] exp_q[$];
  bit          resp_err_q[$];
  logic [31:0] stream_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input int gd, input int rd, input int gp);
    gnt_dly = gd;
    rsp_dly = rd;
    gap     = gp;
  endtask

  task automatic exp_push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d, input bit e);
    exp_q.push_back({a, be, d, 1'b1, 4'h0});
    resp_err_q.push_back(e);
  endtask

  // Scoreboard monitor: every granted request is checked against the queue.
  initial begin
    logic [72:0] act;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && mgr.req && mgr.gnt) begin
        act = {mgr.addr, mgr.be, mgr.wdata, mgr.we, mgr.aid};
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL write_unexpected: got %0h expected none", act);
        end else begin
          chk("write", act, exp_q.pop_front());
        end
      end
    end
  end

  // done_o pulse counter.
  initial begin
    forever begin
      @(negedge clk_i);
      #2;
      if (done_o) done_cnt++;
    end
  end

  // Memory responder: delayed grant, delayed response, stability and
  // single-outstanding checks.
  initial begin
    logic [72:0] snap;
    bit aborted, stable_bad, outst_bad, e;
    int gd, rd;
    mgr.gnt = 1'b0;
    mgr.rvalid = 1'b0;
    mgr.err = 1'b0;
    forever begin
      @(negedge clk_i);
      mgr.gnt = 1'b0;
      mgr.rvalid = 1'b0;
      mgr.err = 1'b0;
      if (rst_ni && mgr.req) begin
        gd = gnt_dly;
        rd = rsp_dly;
        snap = {mgr.addr, mgr.be, mgr.wdata, mgr.we, mgr.aid};
        aborted = 1'b0;
        stable_bad = 1'b0;
        outst_bad = 1'b0;
        for (int i = 0; i < gd; i++) begin
          @(negedge clk_i);
          if (!rst_ni) begin
            aborted = 1'b1;
            break;
          end
          if (!mgr.req) stable_bad = 1'b1;
          if ({mgr.addr, mgr.be, mgr.wdata, mgr.we, mgr.aid} !== snap) stable_bad = 1'b1;
        end
        if (!aborted) begin
          if (gd > 0) chk("req_stable", stable_bad, 1'b0);
          mgr.gnt = 1'b1;
          @(negedge clk_i);
          mgr.gnt = 1'b0;
          for (int i = 0; i < rd; i++) begin
            if (mgr.req) outst_bad = 1'b1;
            @(negedge clk_i);
          end
          if (mgr.req) outst_bad = 1'b1;
          chk("one_outstanding", outst_bad, 1'b0);
          e = (resp_err_q.size() > 0) ? resp_err_q.pop_front() : 1'b0;
          mgr.rvalid = 1'b1;
          mgr.err = e;
        end
      end
    end
  end

  // Stream source: presents queued words with a configurable gap, holds
  // each until accepted; drops a word if the queue is flushed.
  initial begin
    rvalid = 1'b0;
    rdata = '0;
    forever begin
      @(negedge clk_i);
      if (stream_q.size() > 0) begin
        repeat (gap) @(negedge clk_i);
        if (stream_q.size() > 0) begin
          rvalid = 1'b1;
          rdata = stream_q[0];
          forever begin
            #2;
            if (stream_q.size() == 0) begin
              rvalid = 1'b0;
              break;
            end
            if (rready) begin
              @(negedge clk_i);
              void'(stream_q.pop_front());
              rvalid = 1'b0;
              break;
            end
            @(negedge clk_i);
          end
        end
      end
    end
  end

  // Issue one command and wait (bounded) for completion.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] l, input int max_lat);
    int d0, lat;
    bit seen;
    d0 = done_cnt;
    @(negedge clk_i);
    awvalid = 1'b1;
    awaddr = a;
    awlen = l;
    #2;
    chk("awready_idle", awready, 1'b1);
    @(negedge clk_i);
    awvalid = 1'b0;
    #1;
    chk("err_clr_on_accept", err_o, 1'b0);
    #1;
    seen = 1'b0;
    lat = 1;
    for (int i = 0; i < 3000; i++) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
      #2;
      lat++;
    end
    chk("done_seen", seen, 1'b1);
    if (seen) begin
      if (max_lat > 0) chk("done_latency_ok", (lat <= max_lat), 1'b1);
      chk("busy_in_done", busy_o, 1'b1);
      @(negedge clk_i);
      #2;
      chk("busy_after_done", {busy_o, done_o}, 2'b00);
      chk("done_once", done_cnt - d0, 1);
    end
    chk("sb_drained", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    bit seen;
    rst_ni = 1'b0;
    testmode_i = 1'b0;
    awvalid = 1'b0;
    awaddr = '0;
    awlen = '0;
    cfg(0, 0, 0);
    repeat (3) @(negedge clk_i);
    #2;
    chk("rst_awready", awready, 1'b1);
    chk("rst_busy_done_err", {busy_o, done_o, err_o}, 3'b000);
    chk("rst_req_rready", {mgr.req, rready}, 2'b00);
    chk("rst_a_fields", {mgr.addr, mgr.be, mgr.wdata, mgr.we, mgr.aid}, 73'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic two-word transfer, no delays.
    cfg(0, 0, 0);
    stream_q.push_back(32'hA5A5_0001);
    stream_q.push_back(32'hA5A5_0002);
    exp_push(32'h1000_0000, 4'b1111, 32'hA5A5_0001, 1'b0);
    exp_push(32'h1000_0004, 4'b1111, 32'hA5A5_0002, 1'b0);
    run_cmd(32'h1000_0000, 32'd8, 0);

    // Partial last word: 6 bytes.
    stream_q.push_back(32'hDEAD_BEEF);
    stream_q.push_back(32'hCAFE_F00D);
    exp_push(32'h1000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    exp_push(32'h1000_0104, 4'b0011, 32'hCAFE_F00D, 1'b0);
    run_cmd(32'h1000_0100, 32'd6, 0);

    // One byte, unaligned address is truncated.
    stream_q.push_back(32'h8765_4321);
    exp_push(32'h1000_0200, 4'b0001, 32'h8765_4321, 1'b0);
    run_cmd(32'h1000_0203, 32'd1, 0);

    // Three bytes, with one surplus stream word that must stay unconsumed.
    stream_q.push_back(32'h0BAD_CAFE);
    stream_q.push_back(32'hEEEE_EEEE);
    exp_push(32'h1000_0300, 4'b0111, 32'h0BAD_CAFE, 1'b0);
    run_cmd(32'h1000_0300, 32'd3, 0);
    repeat (4) @(negedge clk_i);
    #2;
    chk("excess_not_consumed", {stream_q.size() == 1, rvalid, rready}, 3'b110);
    stream_q.delete();
    repeat (2) @(negedge clk_i);

    // Backpressure on grant, response and stream.
    cfg(5, 3, 4);
    stream_q.push_back(32'h1111_1111);
    stream_q.push_back(32'h2222_2222);
    stream_q.push_back(32'h3333_3333);
    exp_push(32'h3000_0000, 4'b1111, 32'h1111_1111, 1'b0);
    exp_push(32'h3000_0004, 4'b1111, 32'h2222_2222, 1'b0);
    exp_push(32'h3000_0008, 4'b1111, 32'h3333_3333, 1'b0);
    run_cmd(32'h3000_0000, 32'd12, 0);

    // Zero length: no request, done shortly after accept.
    cfg(0, 0, 0);
    run_cmd(32'h3000_0100, 32'd0, 2);

    // Address wrap past the top of the address space.
    stream_q.push_back(32'h0102_0304);
    stream_q.push_back(32'h0506_0708);
    exp_push(32'hFFFF_FFFC, 4'b1111, 32'h0102_0304, 1'b0);
    exp_push(32'h0000_0000, 4'b1111, 32'h0506_0708, 1'b0);
    run_cmd(32'hFFFF_FFFE, 32'd8, 0);

    // Error on the first of three words: all writes still issued.
    stream_q.push_back(32'hAAAA_0000);
    stream_q.push_back(32'hBBBB_0001);
    stream_q.push_back(32'hCCCC_0002);
    exp_push(32'h4000_0000, 4'b1111, 32'hAAAA_0000, 1'b1);
    exp_push(32'h4000_0004, 4'b1111, 32'hBBBB_0001, 1'b0);
    exp_push(32'h4000_0008, 4'b1111, 32'hCCCC_0002, 1'b0);
    run_cmd(32'h4000_0000, 32'd12, 0);
    chk("err_sticky", err_o, 1'b1);

    // Next command clears the error flag.
    stream_q.push_back(32'h9999_0003);
    exp_push(32'h4000_0100, 4'b1111, 32'h9999_0003, 1'b0);
    run_cmd(32'h4000_0100, 32'd4, 0);
    chk("err_after_clean", err_o, 1'b0);

    // Reset while a request is waiting for its grant.
    cfg(60, 0, 0);
    for (int i = 0; i < 4; i++) stream_q.push_back(32'h5000_0000 + i);
    @(negedge clk_i);
    awvalid = 1'b1;
    awaddr = 32'h5000_0000;
    awlen = 32'd16;
    @(negedge clk_i);
    awvalid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #2;
      if (mgr.req) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk("rst_reach_req", seen, 1'b1);
    d0 = done_cnt;
    rst_ni = 1'b0;
    #1;
    chk("midrst_req", mgr.req, 1'b0);
    chk("midrst_awready", awready, 1'b1);
    chk("midrst_busy_rready", {busy_o, rready}, 2'b00);
    stream_q.delete();
    resp_err_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk_i);
    #2;
    chk("midrst_no_done", done_cnt - d0, 0);
    rst_ni = 1'b1;
    cfg(0, 0, 0);
    stream_q.push_back(32'h1234_5678);
    exp_push(32'h2000_0010, 4'b1111, 32'h1234_5678, 1'b0);
    run_cmd(32'h2000_0010, 32'd4, 0);

    repeat (5) @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
